// File: rtl/pipeline_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit_pkg
// Description : Shared stage indices and redirect-FSM encoding for the
//               RV32I pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_unit_pkg;

    // Fixed stage positions at the front of the pipe.
    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_REGFILE = 0;

    // Redirect tracking: PENDING means a taken branch was accepted while IF
    // was blocked, so the wrong-path fetch still has to be squashed.
    typedef enum logic [0:0] {
        REDIR_IDLE    = 1'b0,
        REDIR_PENDING = 1'b1
    } redir_state_t;

endpackage : pipeline_hazard_unit_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_unit_hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Priority encoder over the in-flight scoreboard for one source
//               register. Reports whether a stage will write the register,
//               which stage is the youngest writer, and whether that stage
//               already holds the result.
//               Entry k of the flattened vectors describes stage k+STG_EX.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_W      = 5,
    parameter int STG_W      = 3
) (
    input  logic [REG_W-1:0]                  src,
    input  logic [NUM_STAGES-3:0]             sb_valid,
    input  logic [NUM_STAGES-3:0]             sb_we,
    input  logic [(NUM_STAGES-2)*REG_W-1:0]   sb_rd,
    input  logic [(NUM_STAGES-2)*STG_W-1:0]   sb_ready_stg,
    output logic                              hit,
    output logic [STG_W-1:0]                  stage,
    output logic                              ready
);

    localparam int NUM_SB = NUM_STAGES - 2;

    // Scan oldest to youngest so the youngest matching writer is left last.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        ready = 1'b0;
        for (int k = NUM_SB - 1; k >= 0; k--) begin
            if (sb_valid[k] && sb_we[k] &&
                (sb_rd[k*REG_W +: REG_W] != '0) &&
                (sb_rd[k*REG_W +: REG_W] == src)) begin
                hit   = 1'b1;
                stage = STG_W'(k + STG_EX);
                ready = (sb_ready_stg[k*STG_W +: STG_W] <= STG_W'(k + STG_EX));
            end
        end
    end

endmodule : hazard_match
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Hazard, forwarding and stall/flush controller for the
//               in-order RV32I pipeline. Tracks in-flight destinations per
//               stage, picks forwarding sources for the decode operands,
//               inserts load-use bubbles, merges memory stalls and branch
//               redirects into per-stage stall/flush vectors, and counts
//               hazard and flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_W      = 5,
    parameter int STG_W      = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  id_rd_we,
    input  logic [STG_W-1:0]      id_ready_stg,
    input  logic                  imem_stall,
    input  logic                  dmem_stall,
    input  logic                  ex_redirect,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic [STG_W-1:0]      fwd_rs1_sel,
    output logic [STG_W-1:0]      fwd_rs2_sel,
    output logic                  redirect_pend,
    output logic [CNT_W-1:0]      perf_hazard_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
);

    localparam int NUM_SB = NUM_STAGES - 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic [STG_W-1:0] ready_stg;
    } hazard_sb_entry_t;

    // Scoreboard: sb[k] mirrors the instruction held in stage k+STG_EX.
    hazard_sb_entry_t        sb       [NUM_SB];
    hazard_sb_entry_t        upstream [NUM_SB];
    logic [NUM_SB-1:0]       up_kill;
    hazard_sb_entry_t        id_entry;

    logic [NUM_SB-1:0]       sb_valid;
    logic [NUM_SB-1:0]       sb_we;
    logic [NUM_SB*REG_W-1:0] sb_rd;
    logic [NUM_SB*STG_W-1:0] sb_rdy;

    logic                    rs1_hit, rs1_ready;
    logic                    rs2_hit, rs2_ready;
    logic [STG_W-1:0]        rs1_stage, rs2_stage;
    logic                    load_use;

    logic [NUM_STAGES-1:0]   req_stall;
    logic [NUM_STAGES-1:0]   req_flush;
    logic                    hazard_inc;
    logic                    flush_inc;
    redir_state_t            state;
    redir_state_t            next_state;

    assign id_entry = {1'b1, id_rd, id_rd_we, id_ready_stg};

    // Flatten the scoreboard for the matchers and pick each entry's source:
    // EX takes the decode fields, later stages take the entry ahead of them.
    for (genvar k = 0; k < NUM_SB; k++) begin : g_sb_wiring
        assign sb_valid[k]                 = sb[k].valid;
        assign sb_we[k]                    = sb[k].we;
        assign sb_rd[k*REG_W +: REG_W]     = sb[k].rd;
        assign sb_rdy[k*STG_W +: STG_W]    = sb[k].ready_stg;
        if (k == 0) begin : g_from_id
            assign upstream[k] = id_entry;
            assign up_kill[k]  = stall[STG_ID] | flush[STG_ID] | ~id_valid;
        end else begin : g_from_prev
            assign upstream[k] = sb[k-1];
            assign up_kill[k]  = stall[k + STG_EX - 1];
        end
    end

    hazard_match #(
        .NUM_STAGES   (NUM_STAGES),
        .REG_W        (REG_W),
        .STG_W        (STG_W)
    ) u_match_rs1 (
        .src          (id_rs1),
        .sb_valid     (sb_valid),
        .sb_we        (sb_we),
        .sb_rd        (sb_rd),
        .sb_ready_stg (sb_rdy),
        .hit          (rs1_hit),
        .stage        (rs1_stage),
        .ready        (rs1_ready)
    );

    hazard_match #(
        .NUM_STAGES   (NUM_STAGES),
        .REG_W        (REG_W),
        .STG_W        (STG_W)
    ) u_match_rs2 (
        .src          (id_rs2),
        .sb_valid     (sb_valid),
        .sb_we        (sb_we),
        .sb_rd        (sb_rd),
        .sb_ready_stg (sb_rdy),
        .hit          (rs2_hit),
        .stage        (rs2_stage),
        .ready        (rs2_ready)
    );

    assign fwd_rs1_sel = (rs1_hit && rs1_ready) ? rs1_stage : STG_W'(FWD_REGFILE);
    assign fwd_rs2_sel = (rs2_hit && rs2_ready) ? rs2_stage : STG_W'(FWD_REGFILE);

    // A load-use bubble is needed when a used operand's writer has not yet
    // reached the stage that produces its result.
    assign load_use = id_valid &
                      ((id_rs1_used & rs1_hit & ~rs1_ready) |
                       (id_rs2_used & rs2_hit & ~rs2_ready));

    // Prioritised stall/flush requests and redirect FSM next state.
    always_comb begin
        req_stall  = '0;
        req_flush  = '0;
        hazard_inc = 1'b0;
        flush_inc  = 1'b0;
        next_state = state;
        if (dmem_stall) begin
            // Whole pipe freezes; EX keeps asserting its redirect until then.
            req_stall = '1;
        end else if (ex_redirect) begin
            flush_inc         = 1'b1;
            req_flush[STG_ID] = 1'b1;
            if (imem_stall) begin
                next_state = REDIR_PENDING;
            end else begin
                req_flush[STG_IF] = 1'b1;
                next_state        = REDIR_IDLE;
            end
        end else begin
            // The outstanding wrong-path fetch lands once IF unblocks.
            if ((state == REDIR_PENDING) && !imem_stall) begin
                req_flush[STG_IF] = 1'b1;
                next_state        = REDIR_IDLE;
            end
            if (load_use) begin
                req_stall[STG_IF] = 1'b1;
                req_stall[STG_ID] = 1'b1;
                req_flush[STG_EX] = 1'b1;
                hazard_inc        = 1'b1;
            end else if (imem_stall) begin
                req_stall[STG_IF] = 1'b1;
                req_flush[STG_ID] = 1'b1;
            end
        end
    end

    // A flush always wins over a hold on the same stage.
    assign stall = req_stall & ~req_flush;
    assign flush = req_flush;

    assign redirect_pend = (state == REDIR_PENDING);

    // Redirect FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REDIR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Scoreboard advance: held entries stay, killed slots take a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_SB; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SB; k++) begin
                if (!stall[k + STG_EX]) begin
                    if (flush[k + STG_EX] || up_kill[k]) begin
                        sb[k] <= '0;
                    end else begin
                        sb[k] <= upstream[k];
                    end
                end
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hazard_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (hazard_inc && (perf_hazard_cnt != '1)) begin
                perf_hazard_cnt <= perf_hazard_cnt + CNT_W'(1);
            end
            if (flush_inc && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule : pipeline_hazard_unit
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Directed scoreboard bench. Two hazard units (5-stage/32-bit
//               counters and 6-stage/4-bit counters) share one stimulus
//               stream; expected outputs are queued by the driver and popped
//               by a monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_ready_stg;
    logic       imem_stall, dmem_stall, ex_redirect;

    logic [4:0]  stall5, flush5;
    logic [2:0]  f1_5, f2_5;
    logic        pend5;
    logic [31:0] hc5, fc5;

    logic [5:0]  stall6, flush6;
    logic [2:0]  f1_6, f2_6;
    logic        pend6;
    logic [3:0]  hc6, fc6;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .NUM_STAGES(5), .REG_W(5), .STG_W(3), .CNT_W(32)
    ) dut5 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_ready_stg(id_ready_stg),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .ex_redirect(ex_redirect),
        .stall(stall5), .flush(flush5), .fwd_rs1_sel(f1_5), .fwd_rs2_sel(f2_5),
        .redirect_pend(pend5), .perf_hazard_cnt(hc5), .perf_flush_cnt(fc5)
    );

    pipeline_hazard_unit #(
        .NUM_STAGES(6), .REG_W(5), .STG_W(3), .CNT_W(4)
    ) dut6 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_ready_stg(id_ready_stg),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .ex_redirect(ex_redirect),
        .stall(stall6), .flush(flush6), .fwd_rs1_sel(f1_6), .fwd_rs2_sel(f2_6),
        .redirect_pend(pend6), .perf_hazard_cnt(hc6), .perf_flush_cnt(fc6)
    );

    typedef struct {
        string       name;
        bit          inst;   // 0 = 5-stage unit, 1 = 6-stage unit
        logic [5:0]  st;
        logic [5:0]  fl;
        logic [2:0]  f1;
        logic [2:0]  f2;
        logic        pend;
        logic [31:0] hc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expected entry per presented output sample.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [5:0]  a_st, a_fl;
        logic [2:0]  a_f1, a_f2;
        logic        a_pend;
        logic [31:0] a_hc, a_fc;
        if (q.size() > 0) begin
            e      = q.pop_front();
            a_st   = e.inst ? stall6 : {1'b0, stall5};
            a_fl   = e.inst ? flush6 : {1'b0, flush5};
            a_f1   = e.inst ? f1_6 : f1_5;
            a_f2   = e.inst ? f2_6 : f2_5;
            a_pend = e.inst ? pend6 : pend5;
            a_hc   = e.inst ? {28'd0, hc6} : hc5;
            a_fc   = e.inst ? {28'd0, fc6} : fc5;
            chk(e.name, "stall", 32'(a_st), 32'(e.st));
            chk(e.name, "flush", 32'(a_fl), 32'(e.fl));
            chk(e.name, "excl",  32'(a_st & a_fl), 32'd0);
            chk(e.name, "fwd1",  32'(a_f1), 32'(e.f1));
            chk(e.name, "fwd2",  32'(a_f2), 32'(e.f2));
            chk(e.name, "pend",  32'(a_pend), 32'(e.pend));
            chk(e.name, "hcnt",  a_hc, e.hc);
            chk(e.name, "fcnt",  a_fc, e.fc);
        end
    end

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic [2:0] rdy);
        id_valid = v;  id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd;    id_rd_we = we; id_ready_stg = rdy;
    endtask

    task automatic set_ctl(input logic im, input logic dm, input logic rx);
        imem_stall = im; dmem_stall = dm; ex_redirect = rx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string nm, input bit inst,
                            input logic [5:0] st, input logic [5:0] fl,
                            input logic [2:0] f1, input logic [2:0] f2,
                            input logic pend, input int hc, input int fc);
        exp_t e;
        e.name = nm; e.inst = inst; e.st = st; e.fl = fl; e.f1 = f1; e.f2 = f2;
        e.pend = pend; e.hc = 32'(hc); e.fc = 32'(fc);
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0);
        #1;
        exp_push("reset", 0, 6'b0, 6'b0, 0, 0, 0, 0, 0);
        #11 rst = 1'b1;

        // Load-use: lw x5 then add reading x5.
        tick(); set_id(1, 0, 0, 0, 0, 5, 1, 3);
        exp_push("lw_x5", 0, 6'b0, 6'b0, 0, 0, 0, 0, 0);
        tick(); set_id(1, 5, 1, 0, 1, 7, 1, 2);
        exp_push("load_use", 0, 6'b00011, 6'b00100, 0, 0, 0, 0, 0);
        tick();
        exp_push("fwd_after_bubble", 0, 6'b0, 6'b0, 3, 0, 0, 1, 0);

        // Forwarding: youngest writer wins, x0 never forwards.
        tick(); set_id(1, 0, 0, 0, 0, 6, 1, 2);
        exp_push("add_x6_a", 0, 6'b0, 6'b0, 0, 0, 0, 1, 0);
        tick(); set_id(1, 7, 1, 0, 0, 6, 1, 2);
        exp_push("fwd_x7_ma", 0, 6'b0, 6'b0, 3, 0, 0, 1, 0);
        tick(); set_id(1, 6, 1, 7, 1, 8, 1, 2);
        exp_push("youngest_wins", 0, 6'b0, 6'b0, 2, 4, 0, 1, 0);
        tick(); set_id(1, 6, 1, 0, 0, 0, 1, 2);
        exp_push("x0_writer", 0, 6'b0, 6'b0, 3, 0, 0, 1, 0);
        tick(); set_id(1, 0, 1, 0, 1, 0, 0, 2);
        exp_push("read_x0", 0, 6'b0, 6'b0, 0, 0, 0, 1, 0);

        // Redirect while IF is blocked for three cycles.
        tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); set_ctl(1, 0, 1);
        exp_push("redir_imem", 0, 6'b0, 6'b00010, 0, 0, 0, 1, 0);
        tick(); set_ctl(1, 0, 0);
        exp_push("pend_1", 0, 6'b00001, 6'b00010, 0, 0, 1, 1, 1);
        tick();
        exp_push("pend_2", 0, 6'b00001, 6'b00010, 0, 0, 1, 1, 1);
        tick(); set_ctl(0, 0, 0);
        exp_push("pend_release", 0, 6'b0, 6'b00001, 0, 0, 1, 1, 1);
        tick();
        exp_push("pend_clear", 0, 6'b0, 6'b0, 0, 0, 0, 1, 1);

        // dmem_stall dominates a load-use and a redirect together.
        tick(); set_id(1, 0, 0, 0, 0, 9, 1, 3);
        exp_push("lw_x9", 0, 6'b0, 6'b0, 0, 0, 0, 1, 1);
        tick(); set_id(1, 9, 1, 0, 0, 10, 1, 2); set_ctl(0, 1, 1);
        exp_push("dmem_freeze", 0, 6'b11111, 6'b0, 0, 0, 0, 1, 1);
        tick(); set_ctl(0, 0, 0);
        exp_push("load_use_2", 0, 6'b00011, 6'b00100, 0, 0, 0, 1, 1);
        tick();
        exp_push("fwd_x9", 0, 6'b0, 6'b0, 3, 0, 0, 2, 1);

        // Async reset with a redirect pending and writers in flight.
        tick(); set_id(1, 0, 0, 0, 0, 11, 1, 2); set_ctl(1, 0, 1);
        exp_push("redir_again", 0, 6'b0, 6'b00010, 0, 0, 0, 2, 1);
        tick(); set_id(1, 10, 1, 0, 0, 0, 0, 2); set_ctl(1, 0, 0);
        exp_push("pend_pre_rst", 0, 6'b00001, 6'b00010, 3, 0, 1, 2, 2);
        tick(); rst = 1'b0;
        exp_push("async_rst", 0, 6'b00001, 6'b00010, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Six-stage unit: forward from the last stage.
        tick(); set_ctl(0, 0, 0); set_id(1, 0, 0, 0, 0, 12, 1, 5);
        exp_push("n6_prod", 1, 6'b0, 6'b0, 0, 0, 0, 0, 0);
        tick(); set_id(1, 0, 0, 0, 0, 0, 0, 2);
        exp_push("n6_filler", 1, 6'b0, 6'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick(); set_id(1, 12, 1, 0, 0, 0, 0, 2);
        exp_push("n6_fwd5", 1, 6'b0, 6'b0, 5, 0, 0, 0, 0);

        // Six-stage unit: three bubbles per dependency, 4-bit counter saturates.
        for (int i = 0; i < 6; i++) begin
            tick(); set_id(1, 0, 0, 0, 0, 13, 1, 5);
            tick(); set_id(1, 13, 1, 0, 0, 0, 0, 2);
            exp_push("n6_load_use", 1, 6'b000011, 6'b000100, 0, 0, 0,
                     (3 * i > 15) ? 15 : 3 * i, 0);
            tick();
            tick();
            tick();
            exp_push("n6_sat", 1, 6'b0, 6'b0, 5, 0, 0,
                     (3 * i + 3 > 15) ? 15 : 3 * i + 3, 0);
        end

        for (int k = 0; k < 8 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, 0 required", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_unit
`default_nettype wire
